// File: rtl/regfile_arbiter_pkg.sv
// Shared project definitions for the register-file arbiter: data/address widths,
// FSM encoding and lock-counter width.
package regfile_arbiter_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int DATA_ADDR_WIDTH = 4;
  // Wide enough for any MAX_LOCK up to 255.
  localparam int LOCK_CNT_W      = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr, with
// wrap-around; returns a one-hot grant and the winning index.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates N_REQ requesters onto one external register-file port, with
// round-robin fairness and bounded lock ownership; reads return one cycle later.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int MAX_LOCK = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 i_req,
  input  logic [N_REQ-1:0]                 i_lock,
  input  logic [N_REQ-1:0]                 i_we,
  input  logic [N_REQ*DATA_ADDR_WIDTH-1:0] i_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]      i_wdata,
  output logic [N_REQ-1:0]                 o_gnt,
  output logic [N_REQ-1:0]                 o_rvalid,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [DATA_ADDR_WIDTH-1:0]       o_rf_addr,
  output logic [DATA_WIDTH-1:0]            o_rf_wdata,
  output logic                             o_rf_we,
  input  logic [DATA_WIDTH-1:0]            i_rf_rdata
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e             state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt, rr_ptr, rr_nxt;
  logic [LOCK_CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_REQ-1:0]       pick_gnt, gnt;
  logic [IDX_W-1:0]       pick_idx, gidx;
  logic                   pick_any, gvld, rd_gnt;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    gnt       = '0;
    gidx      = owner;
    gvld      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt    = pick_gnt;
          gidx   = pick_idx;
          gvld   = 1'b1;
          rr_nxt = IDX_W'((int'(pick_idx) + 1) % N_REQ);
          if (i_lock[pick_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = pick_idx;
            cnt_nxt   = LOCK_CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        // A would-be grant at the cap releases instead, so the owner gets exactly MAX_LOCK ops.
        if (!i_lock[owner] || (i_req[owner] && cnt == LOCK_CNT_W'(MAX_LOCK))) begin
          state_nxt = IDLE;
          rr_nxt    = IDX_W'((int'(owner) + 1) % N_REQ);
          cnt_nxt   = '0;
        end else if (i_req[owner]) begin
          gnt[owner] = 1'b1;
          gvld       = 1'b1;
          cnt_nxt    = cnt + LOCK_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      gnt  = '0;
      gvld = 1'b0;
    end
  end

  assign rd_gnt     = gvld && !i_we[gidx];
  assign o_gnt      = gnt;
  assign o_rf_we    = gvld && i_we[gidx];
  assign o_rf_addr  = gvld ? i_addr[gidx*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH] : '0;
  assign o_rf_wdata = gvld ? i_wdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      o_rvalid <= '0;
      o_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      cnt      <= cnt_nxt;
      o_rvalid <= rd_gnt ? gnt : '0;
      if (rd_gnt) o_rdata <= i_rf_rdata;
    end
  end
endmodule
